// File: rtl/pio_mem_bram_wide_pkg.sv
// Shared PIO bus constants for the wide PIO-programmable block RAM.
package pio_mem_bram_wide_pkg;

  // PIO data word width and the top bit of the PIO byte address.
  localparam int PIO_NBITS    = 32;
  localparam int PIO_ADDR_MSB = PIO_NBITS - 1;

endpackage

// File: rtl/ram_1r1w.sv
// Simple dual-port RAM: one write port, one registered-read port.
// A read and a write of the same entry on the same edge return the old data.
module ram_1r1w #(
  parameter int WIDTH       = 72,
  parameter int DEPTH_NBITS = 6
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [DEPTH_NBITS-1:0] waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic [DEPTH_NBITS-1:0] raddr,
  output logic [WIDTH-1:0]       rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_NBITS];

  // Write the addressed entry and register the read word (read-before-write).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/pio_mem_bram_wide.sv
// PIO-programmable 1R1W table whose entries span several PIO dword lanes.
// Lower lanes are staged; writing the top lane commits the whole entry.
// The datapath read port has priority over PIO on the shared read address.
module pio_mem_bram_wide
  import pio_mem_bram_wide_pkg::*;
#(
  parameter int WIDTH       = 72,
  parameter int DEPTH_NBITS = 6,
  parameter int NWORDS      = 3,
  parameter int WSEL_NBITS  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clk_div,
  input  logic [PIO_NBITS-1:0]   reg_addr,
  input  logic [PIO_NBITS-1:0]   reg_din,
  input  logic                   reg_rd,
  input  logic                   reg_wr,
  input  logic                   reg_ms,
  input  logic                   app_mem_rd,
  input  logic [DEPTH_NBITS-1:0] app_mem_raddr,
  output logic                   wr_active,
  output logic [DEPTH_NBITS-1:0] wr_addr,
  output logic [WIDTH-1:0]       wr_data,
  output logic                   mem_ack,
  output logic [PIO_NBITS-1:0]   mem_rdata,
  output logic                   app_mem_ack,
  output logic [WIDTH-1:0]       app_mem_rdata
);

  localparam int LANES_W = NWORDS * PIO_NBITS;

  // Pick one dword lane out of an entry; lanes past the last one read as 0
  // and the top partial lane comes back zero-extended.
  function automatic logic [PIO_NBITS-1:0] lane_pick(
    input logic [WIDTH-1:0]      d,
    input logic [WSEL_NBITS-1:0] l
  );
    logic [LANES_W-1:0] ext;
    ext       = LANES_W'(d);
    lane_pick = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (l == WSEL_NBITS'(i)) begin
        lane_pick = ext[i*PIO_NBITS +: PIO_NBITS];
      end
    end
  endfunction

  // ---- stage p0: PIO decode, staging merge, read-address arbitration ----
  logic [WSEL_NBITS-1:0]  lane_p0;
  logic [DEPTH_NBITS-1:0] entry_p0;
  logic                   pio_wr_p0;
  logic                   pio_rd_p0;
  logic                   top_wr_p0;
  logic [LANES_W-1:0]     staging;
  logic [LANES_W-1:0]     commit_full_p0;
  logic [WIDTH-1:0]       commit_data_p0;

  logic                   app_vld_p1;
  logic                   app_vld_p2;
  logic [DEPTH_NBITS-1:0] app_raddr_p1;

  logic                   rd_pend;
  logic [DEPTH_NBITS-1:0] pend_entry;
  logic [WSEL_NBITS-1:0]  pend_lane;
  logic                   rd_park_p0;
  logic                   rd_issue_p0;
  logic [WSEL_NBITS-1:0]  rd_lane_p0;
  logic [DEPTH_NBITS-1:0] ram_raddr_p0;

  logic                   rd_vld_p1;
  logic [WSEL_NBITS-1:0]  rd_lane_p1;
  logic                   rd_done;
  logic                   n_ack;
  logic [WIDTH-1:0]       ram_rdata_p1;

  logic                   unused_ok;

  assign lane_p0   = reg_addr[2 +: WSEL_NBITS];
  assign entry_p0  = reg_addr[2+WSEL_NBITS +: DEPTH_NBITS];
  assign pio_wr_p0 = reg_wr & reg_ms;
  assign pio_rd_p0 = reg_rd & reg_ms;
  assign top_wr_p0 = pio_wr_p0 && (lane_p0 == WSEL_NBITS'(NWORDS - 1));

  // The top staging lane is never written, so OR-ing in the incoming dword
  // at the top lane position yields the complete entry.
  assign commit_full_p0 = staging | (LANES_W'(reg_din) << ((NWORDS - 1) * PIO_NBITS));
  assign commit_data_p0 = commit_full_p0[WIDTH-1:0];

  // A PIO read that lands while the app owns the read address is parked
  // and replayed on the first free cycle.
  assign rd_park_p0   = pio_rd_p0 && app_vld_p1;
  assign rd_issue_p0  = !app_vld_p1 && (rd_pend || pio_rd_p0);
  assign rd_lane_p0   = rd_pend ? pend_lane : lane_p0;
  assign ram_raddr_p0 = app_vld_p1 ? app_raddr_p1 :
                        (rd_pend ? pend_entry : entry_p0);

  // Address bits outside the lane/entry fields and padding above WIDTH
  // carry no meaning here.
  assign unused_ok = ^{reg_addr, commit_full_p0};

  ram_1r1w #(
    .WIDTH       (WIDTH),
    .DEPTH_NBITS (DEPTH_NBITS)
  ) u_ram (
    .clk   (clk),
    .wr_en (top_wr_p0),
    .waddr (entry_p0),
    .wdata (commit_data_p0),
    .raddr (ram_raddr_p0),
    .rdata (ram_rdata_p1)
  );

  // Control pipeline: app valids, pending/issued PIO reads, ack pacing, commit pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      app_vld_p1  <= 1'b0;
      app_vld_p2  <= 1'b0;
      app_mem_ack <= 1'b0;
      rd_pend     <= 1'b0;
      rd_vld_p1   <= 1'b0;
      rd_done     <= 1'b0;
      n_ack       <= 1'b0;
      mem_ack     <= 1'b0;
      wr_active   <= 1'b0;
    end else begin
      app_vld_p1  <= app_mem_rd;
      app_vld_p2  <= app_vld_p1;
      app_mem_ack <= app_vld_p2;
      rd_vld_p1   <= rd_issue_p0;
      rd_done     <= rd_vld_p1;
      if (rd_park_p0) begin
        rd_pend <= 1'b1;
      end else if (rd_issue_p0) begin
        rd_pend <= 1'b0;
      end
      if (pio_wr_p0 || rd_done) begin
        n_ack <= 1'b1;
      end else if (clk_div) begin
        n_ack <= 1'b0;
      end
      if (clk_div) begin
        mem_ack <= n_ack;
      end
      wr_active <= top_wr_p0;
    end
  end

  // Architecturally visible data: staging lanes, PIO read lane, committed entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging   <= '0;
      mem_rdata <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      for (int i = 0; i < NWORDS - 1; i++) begin
        if (pio_wr_p0 && (lane_p0 == WSEL_NBITS'(i))) begin
          staging[i*PIO_NBITS +: PIO_NBITS] <= reg_din;
        end
      end
      if (rd_vld_p1) begin
        mem_rdata <= lane_pick(ram_rdata_p1, rd_lane_p1);
      end
      if (top_wr_p0) begin
        wr_addr <= entry_p0;
        wr_data <= commit_data_p0;
      end
    end
  end

  // ---- stage p1/p2: unreset data registers riding alongside the valids ----
  // Capture read addresses and the app read word.
  always_ff @(posedge clk) begin
    app_raddr_p1 <= app_mem_raddr;
    if (pio_rd_p0) begin
      pend_entry <= entry_p0;
      pend_lane  <= lane_p0;
    end
    if (rd_issue_p0) begin
      rd_lane_p1 <= rd_lane_p0;
    end
    if (app_vld_p2) begin
      app_mem_rdata <= ram_rdata_p1;
    end
  end

endmodule

// File: tb/tb_pio_mem_bram_wide.sv
// Directed + randomized bench for pio_mem_bram_wide (WIDTH=72, 3 lanes).
module tb_pio_mem_bram_wide;

  logic        clk;
  logic        rst_n;
  logic        clk_div;
  logic [31:0] reg_addr;
  logic [31:0] reg_din;
  logic        reg_rd;
  logic        reg_wr;
  logic        reg_ms;
  logic        app_mem_rd;
  logic [5:0]  app_mem_raddr;
  logic        wr_active;
  logic [5:0]  wr_addr;
  logic [71:0] wr_data;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        app_mem_ack;
  logic [71:0] app_mem_rdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int div_n = 1;
  logic last_div;

  // Reference model: table contents, staging lanes, which entries are known.
  logic [71:0] model_mem [64];
  bit          written   [64];
  logic [31:0] stg       [2];

  pio_mem_bram_wide #(
    .WIDTH(72), .DEPTH_NBITS(6), .NWORDS(3), .WSEL_NBITS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_div(clk_div),
    .reg_addr(reg_addr), .reg_din(reg_din), .reg_rd(reg_rd), .reg_wr(reg_wr),
    .reg_ms(reg_ms), .app_mem_rd(app_mem_rd), .app_mem_raddr(app_mem_raddr),
    .wr_active(wr_active), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .app_mem_ack(app_mem_ack), .app_mem_rdata(app_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; stimulus and sampling happen 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    last_div = clk_div;
    cyc++;
    clk_div = ((cyc % div_n) == 0);
  endtask

  function automatic logic [31:0] addr_of(input int entry, input int lane);
    return 32'((entry << 4) | (lane << 2));
  endfunction

  function automatic logic [31:0] model_lane(input int entry, input int lane);
    logic [95:0] e;
    e = {24'h0, model_mem[entry]};
    if (lane < 3) return e[lane*32 +: 32];
    return 32'h0;
  endfunction

  // Wait for the PIO ack; it must start at a clk_div edge, last one clk_div
  // period, and not repeat.
  task automatic ack_watch(input string tag, input bit chk_data, input logic [31:0] exp_data);
    int waited = 0;
    int len    = 0;
    int extra  = 0;
    while (!mem_ack && waited < 64) begin
      tick();
      waited++;
    end
    check({tag, "_ack_seen"}, mem_ack, 1'b1);
    if (mem_ack) begin
      check({tag, "_ack_on_div"}, last_div, 1'b1);
      if (chk_data) check({tag, "_rdata"}, mem_rdata, exp_data);
      while (mem_ack && len < 64) begin
        len++;
        tick();
      end
      check({tag, "_ack_len"}, len, div_n);
      for (int i = 0; i < 2 * div_n + 2; i++) begin
        if (mem_ack) extra++;
        tick();
      end
      check({tag, "_ack_once"}, extra, 0);
    end
  endtask

  task automatic pio_wr_lane(input string tag, input int entry, input int lane, input logic [31:0] d);
    logic [95:0] full;
    reg_addr = addr_of(entry, lane);
    reg_din  = d;
    reg_wr   = 1'b1;
    reg_ms   = 1'b1;
    tick();
    reg_wr = 1'b0;
    reg_ms = 1'b0;
    if (lane == 2) begin
      full = {d, stg[1], stg[0]};
      model_mem[entry] = full[71:0];
      written[entry]   = 1'b1;
      check({tag, "_wr_active"}, wr_active, 1'b1);
      check({tag, "_wr_addr"}, wr_addr, 6'(entry));
      check({tag, "_wr_data"}, wr_data, model_mem[entry]);
      tick();
      check({tag, "_wr_active_1cyc"}, wr_active, 1'b0);
    end else begin
      if (lane < 2) stg[lane] = d;
      check({tag, "_no_commit"}, wr_active, 1'b0);
    end
    ack_watch(tag, 1'b0, 32'h0);
  endtask

  task automatic pio_wr_full(input string tag, input int entry,
                             input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    pio_wr_lane(tag, entry, 0, d0);
    pio_wr_lane(tag, entry, 1, d1);
    pio_wr_lane(tag, entry, 2, d2);
  endtask

  task automatic pio_read(input string tag, input int entry, input int lane);
    reg_addr = addr_of(entry, lane);
    reg_rd   = 1'b1;
    reg_ms   = 1'b1;
    tick();
    reg_rd = 1'b0;
    reg_ms = 1'b0;
    ack_watch(tag, 1'b1, model_lane(entry, lane));
  endtask

  // App read: request at T, data and ack at T+3 and not earlier.
  task automatic app_read(input string tag, input int entry, input logic [71:0] exp);
    app_mem_rd    = 1'b1;
    app_mem_raddr = 6'(entry);
    tick();
    app_mem_rd = 1'b0;
    tick();
    check({tag, "_app_not_early"}, app_mem_ack, 1'b0);
    tick();
    check({tag, "_app_ack"}, app_mem_ack, 1'b1);
    check({tag, "_app_data"}, app_mem_rdata, exp);
    tick();
    check({tag, "_app_ack_drop"}, app_mem_ack, 1'b0);
  endtask

  initial begin
    int cnt;
    logic [71:0] old9;
    rst_n = 1'b0; clk_div = 1'b1; last_div = 1'b1;
    reg_addr = '0; reg_din = '0; reg_rd = 1'b0; reg_wr = 1'b0; reg_ms = 1'b0;
    app_mem_rd = 1'b0; app_mem_raddr = '0;
    stg[0] = '0; stg[1] = '0;
    for (int i = 0; i < 64; i++) begin
      model_mem[i] = '0;
      written[i]   = 1'b0;
    end
    tick(); tick(); tick();
    check("rst_wr_active", wr_active, 1'b0);
    check("rst_mem_ack", mem_ack, 1'b0);
    check("rst_app_ack", app_mem_ack, 1'b0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    check("rst_wr_addr", wr_addr, 6'h0);
    check("rst_wr_data", wr_data, 72'h0);
    rst_n = 1'b1;
    tick(); tick();

    // Commit of entry 5 through three lanes.
    pio_wr_full("commit5", 5, 32'h11111111, 32'h22222222, 32'h000000AB);
    check("commit5_value", model_mem[5], 72'hAB_22222222_11111111);
    app_read("commit5", 5, 72'hAB_22222222_11111111);

    // Partial write: only lane 0 of entry 7, table unchanged.
    pio_wr_full("init7", 7, 32'hCAFEF00D, 32'h0BADBEEF, 32'h0000005A);
    div_n = 4;
    pio_wr_lane("partial7", 7, 0, 32'hDEADBEEF);
    app_read("partial7", 7, model_mem[7]);

    // Lane reads with a slow ack strobe; lane 3 is out of range.
    pio_read("lane2_e5", 5, 2);
    check("lane2_e5_value", mem_rdata, 32'h000000AB);
    pio_read("lane3_e5", 5, 3);
    pio_read("lane1_e5", 5, 1);
    pio_wr_lane("wr_lane3", 5, 3, 32'hFFFFFFFF);
    app_read("after_lane3", 5, 72'hAB_22222222_11111111);

    // Conflict: three back-to-back app reads, PIO read during the second.
    div_n = 2;
    app_mem_rd = 1'b1; app_mem_raddr = 6'd5;
    tick();
    app_mem_raddr = 6'd7;
    reg_addr = addr_of(5, 0); reg_rd = 1'b1; reg_ms = 1'b1;
    tick();
    reg_rd = 1'b0; reg_ms = 1'b0;
    app_mem_raddr = 6'd5;
    tick();
    app_mem_rd = 1'b0;
    check("conf_ack0", app_mem_ack, 1'b1);
    check("conf_data0", app_mem_rdata, model_mem[5]);
    tick();
    check("conf_ack1", app_mem_ack, 1'b1);
    check("conf_data1", app_mem_rdata, model_mem[7]);
    tick();
    check("conf_ack2", app_mem_ack, 1'b1);
    check("conf_data2", app_mem_rdata, model_mem[5]);
    tick();
    check("conf_ack_end", app_mem_ack, 1'b0);
    ack_watch("conf_pio", 1'b1, model_lane(5, 0));

    // Collision: the app read samples entry 9 on the same edge it is committed.
    div_n = 1;
    pio_wr_full("init9", 9, 32'h01234567, 32'h89ABCDEF, 32'h00000077);
    old9 = model_mem[9];
    pio_wr_lane("coll9_l0", 9, 0, 32'h55555555);
    pio_wr_lane("coll9_l1", 9, 1, 32'h66666666);
    app_mem_rd = 1'b1; app_mem_raddr = 6'd9;
    tick();
    app_mem_rd = 1'b0;
    reg_addr = addr_of(9, 2); reg_din = 32'h00000099; reg_wr = 1'b1; reg_ms = 1'b1;
    tick();
    reg_wr = 1'b0; reg_ms = 1'b0;
    model_mem[9] = 72'h99_66666666_55555555;
    check("coll9_wr_active", wr_active, 1'b1);
    check("coll9_wr_data", wr_data, model_mem[9]);
    tick();
    check("coll9_app_ack", app_mem_ack, 1'b1);
    check("coll9_old_data", app_mem_rdata, old9);
    ack_watch("coll9", 1'b0, 32'h0);
    app_read("coll9_new", 9, 72'h99_66666666_55555555);

    // Randomized mix of commits, app reads and lane reads.
    for (int it = 0; it < 12; it++) begin
      int e;
      int op;
      div_n = $urandom_range(1, 4);
      e  = $urandom_range(16, 23);
      op = $urandom_range(0, 2);
      if (op == 0 || !written[e]) begin
        pio_wr_full("rnd_wr", e, $urandom, $urandom, $urandom);
      end else if (op == 1) begin
        app_read("rnd_app", e, model_mem[e]);
      end else begin
        pio_read("rnd_rd", e, $urandom_range(0, 3));
      end
    end

    // Reset between PIO read issue and its ack.
    div_n = 4;
    pio_read("pre_rst", 5, 2);
    reg_addr = addr_of(5, 0); reg_rd = 1'b1; reg_ms = 1'b1;
    tick();
    reg_rd = 1'b0; reg_ms = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_wr_active", wr_active, 1'b0);
    check("arst_mem_ack", mem_ack, 1'b0);
    check("arst_app_ack", app_mem_ack, 1'b0);
    check("arst_mem_rdata", mem_rdata, 32'h0);
    check("arst_wr_addr", wr_addr, 6'h0);
    check("arst_wr_data", wr_data, 72'h0);
    tick(); tick();
    rst_n = 1'b1;
    stg[0] = '0; stg[1] = '0;
    cnt = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (mem_ack) cnt++;
    end
    check("arst_no_ack", cnt, 0);
    pio_wr_lane("stg_cleared", 12, 2, 32'h000000CD);
    check("stg_cleared_value", model_mem[12], 72'hCD_00000000_00000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
